// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory port arbiter, fetch and LSU blocks
package mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Byte address to doubleword index shift
  localparam int DW_SHIFT = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and RAM signal bundle for the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_wmask;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_wmask;
  logic [DATA_W-1:0] ram_rdata;

  // Requesters and RAM model side
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
    output ram_rdata
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
    output ls_gnt, ls_rvalid, ls_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
    input  ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating count of load/store wins over a waiting fetch
module starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;

  // Clear wins over increment; increment stops at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-at-a-time sharing of a fixed-latency RAM between fetch and load/store
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              is_store, is_store_nxt;
  logic [CNT_W-1:0]  lat_cnt, lat_cnt_nxt;

  logic              starve_inc;
  logic              starve_clr;
  logic              starve_full;

  starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .full  (starve_full)
  );

  // Transaction state: phase, owner, store flag and latency count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= OWN_IF;
      is_store <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      is_store <= is_store_nxt;
      lat_cnt  <= lat_cnt_nxt;
    end
  end

  // Arbitration, RAM drive and completion; outputs held at 0 while reset is asserted
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    is_store_nxt  = is_store;
    lat_cnt_nxt   = lat_cnt;
    starve_inc    = 1'b0;
    starve_clr    = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rdata  = '0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_wmask = '0;

    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          // Any idle cycle without a pending fetch ends a starvation run
          starve_clr = !bus.if_req;
          if (bus.ls_req && !(bus.if_req && starve_full)) begin
            bus.ls_gnt   = 1'b1;
            bus.ram_en   = 1'b1;
            bus.ram_we   = bus.ls_we;
            bus.ram_addr = ADDR_W'(bus.ls_addr >> DW_SHIFT);
            if (bus.ls_we) begin
              bus.ram_wdata = bus.ls_wdata;
              bus.ram_wmask = bus.ls_wmask;
            end
            starve_inc   = bus.if_req;
            owner_nxt    = OWN_LS;
            is_store_nxt = bus.ls_we;
            lat_cnt_nxt  = CNT_ONE;
            state_nxt    = ST_WAIT;
          end else if (bus.if_req) begin
            bus.if_gnt   = 1'b1;
            bus.ram_en   = 1'b1;
            bus.ram_addr = ADDR_W'(bus.if_addr >> DW_SHIFT);
            starve_clr   = 1'b1;
            owner_nxt    = OWN_IF;
            is_store_nxt = 1'b0;
            lat_cnt_nxt  = CNT_ONE;
            state_nxt    = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (lat_cnt == LAT_CNT) begin
            // Read data is forwarded straight from the RAM in the completion cycle
            if (owner == OWN_IF) begin
              bus.if_rvalid = 1'b1;
              bus.if_rdata  = bus.ram_rdata;
            end else begin
              bus.ls_rvalid = 1'b1;
              bus.ls_rdata  = is_store ? DATA_W'(0) : bus.ram_rdata;
            end
            lat_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
          end else begin
            lat_cnt_nxt = lat_cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector and sequence checks for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic        L0 = 1'b0;
  localparam logic        L1 = 1'b1;
  localparam logic [63:0] Z  = 64'h0;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b2 ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(1), .STARVE_MAX(4)) u1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (b1.slave)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(2), .STARVE_MAX(4)) u2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (b2.slave)
  );

  typedef struct {
    logic        ifr;
    logic [63:0] ifa;
    logic        lsr;
    logic        lswe;
    logic [63:0] lsa;
    logic [63:0] lsd;
    logic [63:0] lsm;
    logic [63:0] rd;
    logic        e_ig;
    logic        e_lg;
    logic        e_en;
    logic        e_we;
    logic [63:0] e_addr;
    logic [63:0] e_wd;
    logic [63:0] e_wm;
    logic        e_iv;
    logic [63:0] e_ird;
    logic        e_lv;
    logic [63:0] e_lrd;
  } vec_t;

  vec_t vecs[15];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out1();
    return {58'h0, b1.if_gnt, b1.ls_gnt, b1.if_rvalid, b1.ls_rvalid, b1.ram_en, b1.ram_we}
         | b1.ram_addr | b1.ram_wdata | b1.ram_wmask | b1.if_rdata | b1.ls_rdata;
  endfunction

  task automatic drive_b2(input logic ifr, input logic lsr);
    b2.if_req = ifr;
    b2.ls_req = lsr;
  endtask

  int  gc[$];
  logic gt[$];
  logic exp_t[6];

  initial begin
    b1.if_req = 1'b1; b1.if_addr = 64'h8000_0000; b1.ls_req = 1'b1; b1.ls_we = 1'b1;
    b1.ls_addr = 64'h8; b1.ls_wdata = '1; b1.ls_wmask = '1; b1.ram_rdata = '1;
    b2.if_req = 1'b0; b2.if_addr = 64'h100; b2.ls_req = 1'b0; b2.ls_we = 1'b0;
    b2.ls_addr = 64'h200; b2.ls_wdata = Z; b2.ls_wmask = Z; b2.ram_rdata = Z;

    //          ifr ifa                    lsr lswe lsa       lsd       lsm       rd
    //          ig  lg  en  we  addr                   wd        wm        iv  ird       lv  lrd
    vecs[0]  = '{L0, Z, L0, L0, Z, Z, Z, Z,
                 L0, L0, L0, L0, Z, Z, Z, L0, Z, L0, Z};
    vecs[1]  = '{L1, 64'h8000_0008, L0, L0, Z, Z, Z, Z,
                 L1, L0, L1, L0, 64'h1000_0001, Z, Z, L0, Z, L0, Z};
    vecs[2]  = '{L0, Z, L0, L0, Z, Z, Z, 64'h1234,
                 L0, L0, L0, L0, Z, Z, Z, L1, 64'h1234, L0, Z};
    vecs[3]  = '{L0, Z, L1, L1, 64'h10, 64'hAB, 64'hFF, Z,
                 L0, L1, L1, L1, 64'h2, 64'hAB, 64'hFF, L0, Z, L0, Z};
    vecs[4]  = '{L0, Z, L0, L0, Z, Z, Z, 64'h5555,
                 L0, L0, L0, L0, Z, Z, Z, L0, Z, L1, Z};
    vecs[5]  = '{L0, Z, L1, L0, 64'h18, 64'hCC, 64'hF0, Z,
                 L0, L1, L1, L0, 64'h3, Z, Z, L0, Z, L0, Z};
    vecs[6]  = '{L0, Z, L0, L0, Z, Z, Z, 64'hDEAD,
                 L0, L0, L0, L0, Z, Z, Z, L0, Z, L1, 64'hDEAD};
    vecs[7]  = '{L1, 64'h20, L1, L0, 64'h28, Z, Z, Z,
                 L0, L1, L1, L0, 64'h5, Z, Z, L0, Z, L0, Z};
    vecs[8]  = '{L1, 64'h20, L0, L0, Z, Z, Z, 64'h77,
                 L0, L0, L0, L0, Z, Z, Z, L0, Z, L1, 64'h77};
    vecs[9]  = '{L1, 64'h20, L0, L0, Z, Z, Z, Z,
                 L1, L0, L1, L0, 64'h4, Z, Z, L0, Z, L0, Z};
    vecs[10] = '{L0, Z, L0, L0, Z, Z, Z, 64'h99,
                 L0, L0, L0, L0, Z, Z, Z, L1, 64'h99, L0, Z};
    vecs[11] = '{L1, 64'hFFFF_FFFF_FFFF_FFF8, L0, L0, Z, Z, Z, Z,
                 L1, L0, L1, L0, 64'h1FFF_FFFF_FFFF_FFFF, Z, Z, L0, Z, L0, Z};
    vecs[12] = '{L0, Z, L1, L0, 64'h30, Z, Z, 64'h42,
                 L0, L0, L0, L0, Z, Z, Z, L1, 64'h42, L0, Z};
    vecs[13] = '{L0, Z, L1, L0, 64'h30, Z, Z, Z,
                 L0, L1, L1, L0, 64'h6, Z, Z, L0, Z, L0, Z};
    vecs[14] = '{L0, Z, L0, L0, Z, Z, Z, 64'hFFFF_0000_FFFF_0000,
                 L0, L0, L0, L0, Z, Z, Z, L0, Z, L1, 64'hFFFF_0000_FFFF_0000};

    // Reset state with requests present
    @(negedge clk);
    check("reset_outputs_zero", all_out1(), Z);
    next_cycle();
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    b1.if_req = 1'b0; b1.ls_req = 1'b0; b1.ls_we = 1'b0;

    // Table-driven vectors on the LAT=1 instance
    for (int i = 0; i < 15; i++) begin
      b1.if_req = vecs[i].ifr;   b1.if_addr = vecs[i].ifa;
      b1.ls_req = vecs[i].lsr;   b1.ls_we = vecs[i].lswe;
      b1.ls_addr = vecs[i].lsa;  b1.ls_wdata = vecs[i].lsd;
      b1.ls_wmask = vecs[i].lsm; b1.ram_rdata = vecs[i].rd;
      @(negedge clk);
      check($sformatf("v%0d if_gnt", i),    {63'h0, b1.if_gnt},    {63'h0, vecs[i].e_ig});
      check($sformatf("v%0d ls_gnt", i),    {63'h0, b1.ls_gnt},    {63'h0, vecs[i].e_lg});
      check($sformatf("v%0d ram_en", i),    {63'h0, b1.ram_en},    {63'h0, vecs[i].e_en});
      check($sformatf("v%0d ram_we", i),    {63'h0, b1.ram_we},    {63'h0, vecs[i].e_we});
      check($sformatf("v%0d ram_addr", i),  b1.ram_addr,           vecs[i].e_addr);
      check($sformatf("v%0d ram_wdata", i), b1.ram_wdata,          vecs[i].e_wd);
      check($sformatf("v%0d ram_wmask", i), b1.ram_wmask,          vecs[i].e_wm);
      check($sformatf("v%0d if_rvalid", i), {63'h0, b1.if_rvalid}, {63'h0, vecs[i].e_iv});
      check($sformatf("v%0d if_rdata", i),  b1.if_rdata,           vecs[i].e_ird);
      check($sformatf("v%0d ls_rvalid", i), {63'h0, b1.ls_rvalid}, {63'h0, vecs[i].e_lv});
      check($sformatf("v%0d ls_rdata", i),  b1.ls_rdata,           vecs[i].e_lrd);
      next_cycle();
    end
    b1.ls_req = 1'b0; b1.ram_rdata = Z;

    // Reset in the middle of a fetch
    b1.if_req = 1'b1; b1.if_addr = 64'h8000_0010;
    @(negedge clk);
    check("rst_mid gnt", {63'h0, b1.if_gnt}, 64'h1);
    check("rst_mid addr", b1.ram_addr, 64'h1000_0002);
    next_cycle();
    rst1_n = 1'b0;
    b1.ls_req = 1'b1; b1.ram_rdata = 64'h5A5A;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid zero%0d", k), all_out1(), Z);
      next_cycle();
    end
    rst1_n = 1'b1;
    b1.if_req = 1'b0; b1.ls_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid no_rvalid%0d", k), {62'h0, b1.if_rvalid, b1.ls_rvalid}, Z);
      next_cycle();
    end
    b1.if_req = 1'b1; b1.if_addr = 64'h40;
    @(negedge clk);
    check("post_rst gnt", {63'h0, b1.if_gnt}, 64'h1);
    check("post_rst addr", b1.ram_addr, 64'h8);
    next_cycle();
    b1.if_req = 1'b0; b1.ram_rdata = 64'hABC;
    @(negedge clk);
    check("post_rst rvalid", {63'h0, b1.if_rvalid}, 64'h1);
    check("post_rst rdata", b1.if_rdata, 64'hABC);
    next_cycle();

    // Contention on the LAT=2 instance
    exp_t = '{L0, L0, L0, L0, L1, L0};
    for (int k = 0; k < 40 && gc.size() < 6; k++) begin
      drive_b2(1'b1, 1'b1);
      @(negedge clk);
      if (b2.if_gnt || b2.ls_gnt) begin
        gc.push_back(k);
        gt.push_back(b2.if_gnt);
        check($sformatf("cont one_gnt%0d", k), {63'h0, b2.if_gnt & b2.ls_gnt}, Z);
      end
      next_cycle();
    end
    check("cont grant_count", 64'(gc.size()), 64'd6);
    for (int i = 0; i < gc.size(); i++) begin
      check($sformatf("cont type%0d", i), {63'h0, gt[i]}, {63'h0, exp_t[i]});
      check($sformatf("cont cycle%0d", i), 64'(gc[i]), 64'(3 * i));
    end
    for (int k = 0; k < 3; k++) begin
      drive_b2(1'b0, 1'b0);
      next_cycle();
    end

    // Fetch withdrawn during WAIT clears the starve count in the next IDLE cycle
    gc.delete();
    gt.delete();
    for (int k = 0; k < 27; k++) begin
      drive_b2(!(k == 8 || k == 9), 1'b1);
      @(negedge clk);
      if (b2.if_gnt || b2.ls_gnt) begin
        gc.push_back(k);
        gt.push_back(b2.if_gnt);
      end
      next_cycle();
    end
    check("wd grant_count", 64'(gc.size()), 64'd9);
    for (int i = 0; i < gc.size(); i++) begin
      check($sformatf("wd type%0d", i), {63'h0, gt[i]}, {63'h0, (i == 8) ? L1 : L0});
      check($sformatf("wd cycle%0d", i), 64'(gc[i]), 64'(3 * i));
    end
    drive_b2(1'b0, 1'b0);
    next_cycle();

    // Store completion with LAT=2
    b2.ls_req = 1'b1; b2.ls_we = 1'b1; b2.ls_addr = 64'h10;
    b2.ls_wdata = 64'hAB; b2.ls_wmask = 64'hFF;
    @(negedge clk);
    check("st2 gnt", {63'h0, b2.ls_gnt}, 64'h1);
    check("st2 we", {63'h0, b2.ram_we}, 64'h1);
    check("st2 addr", b2.ram_addr, 64'h2);
    check("st2 wmask", b2.ram_wmask, 64'hFF);
    check("st2 wdata", b2.ram_wdata, 64'hAB);
    next_cycle();
    b2.ls_req = 1'b0; b2.ram_rdata = 64'hFFFF;
    @(negedge clk);
    check("st2 early_rvalid", {63'h0, b2.ls_rvalid}, Z);
    next_cycle();
    @(negedge clk);
    check("st2 rvalid", {63'h0, b2.ls_rvalid}, 64'h1);
    check("st2 rdata", b2.ls_rdata, Z);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency, doubleword-wide RAM between the instruction-fetch requester and the load/store requester of the core. One transaction is in flight at a time. Load/store has priority, subject to an anti-starvation limit that forces a fetch grant. The block sits between the fetch/decode front end and the unified memory model used by simulation and difftest.

## Interface
Parameters:
- `ADDR_W`, 64, byte address width of both requesters.
- `DATA_W`, 64, data width; `ram_wmask` is `DATA_W` bits (bit mask).
- `LAT`, 1, RAM read latency in cycles from `ram_en` to valid `ram_rdata`; legal range ≥1.
- `STARVE_MAX`, 4, consecutive load/store grants allowed while `if_req` is pending; legal range ≥1.

Ports:
- `clk` in 1: the single clock. Reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request.
- `if_addr` in `ADDR_W`: fetch byte address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out `DATA_W`: fetch data.
- `ls_req` in 1: load/store request.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_addr` in `ADDR_W`: load/store byte address.
- `ls_wdata` in `DATA_W`: store data.
- `ls_wmask` in `DATA_W`: store bit mask.
- `ls_gnt` out 1: load/store accepted this cycle.
- `ls_rvalid` out 1: load data valid, or store completion.
- `ls_rdata` out `DATA_W`: load data; 0 for a store.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 1: RAM write.
- `ram_addr` out `ADDR_W`: doubleword index, i.e. byte address >> 3.
- `ram_wdata` out `DATA_W`: RAM write data.
- `ram_wmask` out `DATA_W`: RAM write mask.
- `ram_rdata` in `DATA_W`: RAM read data.

## Operation
- The state machine has two states, `IDLE` and `WAIT`. A registered owner flag (`OWN_IF` or `OWN_LS`) records the granted requester, and a latency counter counts 0..`LAT`.
- `IDLE`:
  - If any request is present, arbitrate, assert exactly one of `if_gnt`/`ls_gnt` together with `ram_en`, drive the RAM fields from the winner, load the counter to 1, and go to `WAIT`.
  - With no request, all strobes are 0.
- Arbitration:
  - `ls_req` alone, or both requests with starve count < `STARVE_MAX`: load/store wins.
  - `if_req` alone, or both requests with starve count == `STARVE_MAX`: fetch wins.
- Starve counter:
  - Increments on each load/store grant issued while `if_req`=1.
  - Clears on a fetch grant, and in any `IDLE` cycle with `if_req`=0.
  - Saturates at `STARVE_MAX`.
- `WAIT`:
  - The counter increments each cycle.
  - When it equals `LAT`, pulse the owner's `rvalid` for one cycle and return to `IDLE`.
  - The owner's `rdata` is `ram_rdata` passed through combinationally in that cycle. For a store, `ls_rdata`=0.
  - No grants and `ram_en`=0 throughout `WAIT`.
- Stores write the RAM in the grant cycle (`ram_we`=1, mask as given) and still complete through the `WAIT` path, so both requesters see a uniform protocol.
- Requesters hold `req` and their fields stable until `gnt`. Dropping `req` before `gnt` is legal and withdraws the request.
- A requester seeing `gnt` must not depend on `rvalid` arriving in the same cycle.
- The non-owner's `rvalid` is never asserted. Its `rdata` output is 0.

## Timing
- Reset (`rst_n`=0, asynchronous) clears the following:
  - State returns to `IDLE`; counters go to 0.
  - `if_gnt`, `ls_gnt`, `if_rvalid`, `ls_rvalid`, `ram_en` and `ram_we` are all 0.
  - Data and address outputs are 0.
  - An in-flight transaction is dropped; no `rvalid` is produced for it after reset releases.
- Grant and `ram_en` are combinational from the requests in `IDLE`.
- Latency: a grant in cycle T produces `rvalid` in cycle T+`LAT`.
- The next grant is possible at T+`LAT`+1, giving a peak throughput of one access per `LAT`+1 cycles.
- Simultaneous `if_req` and `ls_req` in `IDLE` resolve as in Operation. A request arriving during `WAIT` waits for `IDLE`.
- In the `rvalid` cycle the block is still in `WAIT`, so a new grant is never issued in that cycle.

## Structure
- The shared package `mem_pkg` holds the state encoding (`ST_IDLE`, `ST_WAIT`), the owner encoding (`OWN_IF`, `OWN_LS`) and the `>> 3` doubleword shift constant, so they are reused by the fetch and LSU blocks.
- One natural sub-module is `starve_ctr`: a saturating counter with increment, clear and full outputs, parameterised by `STARVE_MAX`.
- Everything else stays flat in `mem_port_arbiter`.

## Test plan
- **Reset mid-transaction** (`LAT`=1): stimulus is `if_req`, `if_addr`=0x8000_0010, then `rst_n`=0 during `WAIT` and released 2 cycles later. Required: every output is 0 during reset, `if_rvalid` never rises for the dropped fetch, and the next `if_req` is granted normally.
- **Single fetch** (`LAT`=1): `if_req`, `if_addr`=0x8000_0008, `ram_rdata`=0x1234. Required: `if_gnt`, `ram_en`=1 and `ram_addr`=0x1000_0001 in cycle T; `if_rvalid`=1 with `if_rdata`=0x1234 at T+1.
- **Contention**: both requests held continuously, `STARVE_MAX`=4, `LAT`=2. Required grant order is LS, LS, LS, LS, IF, LS…, with a grant every 3 cycles.
- **Store**: `ls_we`=1, `ls_addr`=0x10, `ls_wdata`=0xAB, `ls_wmask`=0xFF. Required: `ram_we`=1, `ram_addr`=0x2 and `ram_wmask`=0xFF in the grant cycle; `ls_rvalid`=1 with `ls_rdata`=0 at T+`LAT`.
- **Request withdrawal**: assert `if_req` during `WAIT`, then drop it before `IDLE`. Required: no `if_gnt`, and the starve counter is cleared in the next `IDLE` cycle.
